// File: rtl/ushift_pkg.sv
// ---------------------------------------------------------------------------
// ushift_pkg
//   Shared definitions for the universal shift register:
//   - mode_e   : operation encoding. Values 0-3 keep the legacy 4-bit register
//                encoding (hold, load, shift right, rotate left).
//   - state_e  : sequencing FSM states.
//   - is_shift : true for modes that move bits (SHR/ROL/SHL/ROR/ASR).
// ---------------------------------------------------------------------------
package ushift_pkg;

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_LOAD  = 3'b001,
        M_SHR   = 3'b010,
        M_ROL   = 3'b011,
        M_SHL   = 3'b100,
        M_ROR   = 3'b101,
        M_ASR   = 3'b110,
        M_CLEAR = 3'b111
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    function automatic logic is_shift(input logic [2:0] m);
        return (m == M_SHR) || (m == M_ROL) || (m == M_SHL) ||
               (m == M_ROR) || (m == M_ASR);
    endfunction

endpackage

// File: rtl/ushift_step.sv
// ---------------------------------------------------------------------------
// ushift_step
//   Combinational one-position shift/rotate of q for the given mode.
//   Non-shift modes pass q through unchanged.
// Ports:
//   q      in   WIDTH  current register value
//   mode   in   3      operation (ushift_pkg::mode_e encoding)
//   si     in   1      serial fill bit for SHR (enters MSB) / SHL (enters LSB)
//   q_next out  WIDTH  value after one position
// ---------------------------------------------------------------------------
module ushift_step
    import ushift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             si,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (mode)
            M_SHR:   q_next = {si, q[WIDTH-1:1]};
            M_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            M_SHL:   q_next = {q[WIDTH-2:0], si};
            M_ROR:   q_next = {q[0], q[WIDTH-1:1]};
            M_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
//   WIDTH-bit universal shift register with 8 modes and multi-position
//   shifts of amt positions under a start/busy/done handshake.
//   Build option USHIFT_BARREL_EN: every command completes in the accept
//   cycle through a barrel shifter; busy stays 0. Undefined (default): shifts
//   advance one position per clock through ushift_step.
// Ports:
//   clk    in   1      system clock, rising edge
//   reset  in   1      asynchronous active-high reset
//   start  in   1      command strobe, accepted only while busy==0
//   mode   in   3      operation, sampled at accept
//   amt    in   AW     shift distance 0..WIDTH-1, sampled at accept
//   si     in   1      serial fill bit (live each step in serial build)
//   D      in   WIDTH  parallel load data, sampled at accept
//   Q      out  WIDTH  register contents
//   so_r   out  1      Q[0]
//   so_l   out  1      Q[WIDTH-1]
//   busy   out  1      multi-cycle shift in progress
//   done   out  1      one-cycle completion pulse
//
// state  | meaning
// S_IDLE | waiting for start; single-cycle commands complete here
// S_RUN  | serial shift, one position per clock, cnt positions remaining
// ---------------------------------------------------------------------------
module univ_shift_reg
    import ushift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AW-1:0]    amt,
    input  logic             si,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             so_r,
    output logic             so_l,
    output logic             busy,
    output logic             done
);

    state_e state;

    assign so_r = Q[0];
    assign so_l = Q[WIDTH-1];

`ifdef USHIFT_BARREL_EN

    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] fill_r;
    logic [WIDTH-1:0] fill_l;
    logic [WIDTH-1:0] barrel_q;

    assign ones = '1;

    // Fill masks cover the amt vacated positions; all take the si seen at accept.
    always_comb begin
        fill_r   = si ? ~(ones >> amt) : '0;
        fill_l   = si ? ~(ones << amt) : '0;
        barrel_q = Q;
        case (mode)
            M_LOAD:  barrel_q = D;
            M_CLEAR: barrel_q = '0;
            M_SHR:   barrel_q = (Q >> amt) | fill_r;
            M_SHL:   barrel_q = (Q << amt) | fill_l;
            // amt==0 makes the wrap term shift by WIDTH, which yields zero.
            M_ROL:   barrel_q = (Q << amt) | (Q >> (WIDTH - int'(amt)));
            M_ROR:   barrel_q = (Q >> amt) | (Q << (WIDTH - int'(amt)));
            M_ASR:   barrel_q = $signed(Q) >>> amt;
            default: barrel_q = Q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= S_IDLE;
        end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
            done  <= 1'b0;
            if (start) begin
                Q    <= barrel_q;
                done <= 1'b1;
            end
        end
    end

`else

    logic [AW-1:0]    cnt;
    logic [2:0]       mode_r;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] single_q;

    ushift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q      (Q),
        .mode   (mode_r),
        .si     (si),
        .q_next (step_q)
    );

    // Result of a command that completes at accept (non-shift, or amt==0).
    always_comb begin
        case (mode)
            M_LOAD:  single_q = D;
            M_CLEAR: single_q = '0;
            default: single_q = Q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            state  <= S_IDLE;
            cnt    <= '0;
            mode_r <= M_HOLD;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (is_shift(mode) && (amt != '0)) begin
                            mode_r <= mode;
                            cnt    <= amt;
                            busy   <= 1'b1;
                            state  <= S_RUN;
                        end else begin
                            Q    <= single_q;
                            done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // start is ignored here: no command queueing while busy.
                    Q    <= step_q;
                    cnt  <= cnt - 1'b1;
                    done <= 1'b0;
                    if (cnt == AW'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic          si;
    logic [W-1:0]  D;
    logic [W-1:0]  Q;
    logic          so_r;
    logic          so_l;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] model;

`ifdef USHIFT_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mode  (mode),
        .amt   (amt),
        .si    (si),
        .D     (D),
        .Q     (Q),
        .so_r  (so_r),
        .so_l  (so_l),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit mode_moves(input logic [2:0] m);
        return (m >= 3'd2) && (m <= 3'd6);
    endfunction

    // Register held as a bit queue, index 0 = LSB; each position is a push/pop.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] q, input logic [2:0] m,
                                               input int n, input logic s);
        bit b[$];
        bit x;
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) b.push_back(q[i]);
        for (int k = 0; k < n; k++) begin
            case (m)
                3'd2: begin x = b.pop_front(); b.push_back(s);  end
                3'd3: begin x = b.pop_back();  b.push_front(x); end
                3'd4: begin x = b.pop_back();  b.push_front(s); end
                3'd5: begin x = b.pop_front(); b.push_back(x);  end
                3'd6: begin x = b[W-1]; void'(b.pop_front()); b.push_back(x); end
                default: ;
            endcase
        end
        for (int i = 0; i < W; i++) r[i] = b[i];
        return r;
    endfunction

    function automatic logic [W-1:0] ref_cmd(input logic [W-1:0] q, input logic [2:0] m,
                                             input int n, input logic [W-1:0] d, input logic s);
        if (m == 3'd1) return d;
        if (m == 3'd7) return '0;
        if (m == 3'd0) return q;
        return ref_shift(q, m, n, s);
    endfunction

    // Called #1 after an edge. Issues one command, follows it to completion,
    // checks every cycle, then checks that done falls.
    task automatic run_cmd(input logic [2:0] m, input logic [AW-1:0] a, input logic [W-1:0] d,
                           input logic s, input bit poke);
        logic s_used;
        start = 1'b1; mode = m; amt = a; D = d; si = s;
        @(posedge clk); #1;
        start = 1'b0; mode = 3'($urandom); amt = AW'($urandom); D = W'($urandom);
        if (!mode_moves(m) || a == 0 || BARREL) begin
            model = ref_cmd(model, m, int'(a), d, s);
            chk("q_single", Q, model);
            chk("done_single", done, 1'b1);
            chk("busy_single", busy, 1'b0);
        end else begin
            chk("q_accept", Q, model);
            chk("busy_accept", busy, 1'b1);
            chk("done_accept", done, 1'b0);
            for (int k = 1; k <= int'(a); k++) begin
                si     = 1'($urandom);
                s_used = si;
                start  = poke ? 1'($urandom) : 1'b0;
                @(posedge clk); #1;
                model = ref_shift(model, m, 1, s_used);
                chk("q_step", Q, model);
                chk("busy_step", busy, (k < int'(a)));
                chk("done_step", done, (k == int'(a)));
            end
            start = 1'b0;
        end
        chk("so_r", so_r, model[0]);
        chk("so_l", so_l, model[W-1]);
        @(posedge clk); #1;
        chk("done_fall", done, 1'b0);
        chk("q_hold", Q, model);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 3'd0; amt = '0; si = 1'b0; D = '0;
        model = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", Q, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // LOAD A5
        run_cmd(3'd1, 3'd0, 8'hA5, 1'b0, 1'b0);
        chk("load_a5", Q, 8'hA5);

        // ROL 3 on 81
        run_cmd(3'd1, 3'd0, 8'h81, 1'b0, 1'b0);
        run_cmd(3'd3, 3'd3, 8'h00, 1'b0, 1'b0);
        chk("rol3_81", Q, 8'h0C);

        // ASR 4 on 90
        run_cmd(3'd1, 3'd0, 8'h90, 1'b0, 1'b0);
        run_cmd(3'd6, 3'd4, 8'h00, 1'b0, 1'b0);
        chk("asr4_90", Q, 8'hF9);

        // ROR 1 on 01, then ROR 0
        run_cmd(3'd1, 3'd0, 8'h01, 1'b0, 1'b0);
        run_cmd(3'd5, 3'd1, 8'h00, 1'b0, 1'b0);
        chk("ror1_01", Q, 8'h80);
        run_cmd(3'd5, 3'd0, 8'h00, 1'b0, 1'b0);
        chk("ror0", Q, 8'h80);

        // CLEAR, and HOLD keeps value
        run_cmd(3'd7, 3'd5, 8'h5A, 1'b1, 1'b0);
        chk("clear", Q, 8'h00);
        run_cmd(3'd1, 3'd0, 8'h3C, 1'b0, 1'b0);
        run_cmd(3'd0, 3'd2, 8'hFF, 1'b1, 1'b0);
        chk("hold", Q, 8'h3C);

        // start in the done cycle is accepted
        start = 1'b1; mode = 3'd1; amt = '0; D = 8'h11;
        @(posedge clk); #1;
        mode = 3'd1; D = 8'h22;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_q", Q, 8'h22);
        chk("b2b_done", done, 1'b1);
        @(posedge clk); #1;
        chk("b2b_done_fall", done, 1'b0);
        model = 8'h22;

        // random commands; starts poked during busy must be ignored
        for (int i = 0; i < 60; i++) begin
            run_cmd(3'($urandom), AW'($urandom_range(0, W - 1)), W'($urandom), 1'($urandom),
                    1'b1);
        end

        // reset in the middle of a shift
        run_cmd(3'd1, 3'd0, 8'hC3, 1'b0, 1'b0);
        start = 1'b1; mode = 3'd3; amt = 3'd6; si = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("midrst_q", Q, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        model = '0;
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_q", Q, 8'h00);

        // SHL 2 si=0 on FF, SHR 2 si=1 on 00 (fixed si for the whole shift)
        start = 1'b1; mode = 3'd1; amt = '0; D = 8'hFF;
        @(posedge clk); #1;
        mode = 3'd4; amt = 3'd2; si = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) break;
        end
        chk("shl2_ff", Q, 8'hFC);
        @(posedge clk); #1;
        start = 1'b1; mode = 3'd7;
        @(posedge clk); #1;
        mode = 3'd2; amt = 3'd2; si = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) break;
        end
        chk("shr2_00", Q, 8'hC0);
        chk("shr2_done", done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
